// File: rtl/pc_pipe_chain_if.sv
// pc_pipe_chain_if: ID-side inputs, per-stage controls and stage outputs of the PC/prediction pipeline chain.
interface pc_pipe_chain_if #(
    parameter int XLEN   = 32,
    parameter int META_W = 1,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
);
    logic                     in_valid;
    logic [XLEN-1:0]          in_pc;
    logic [META_W-1:0]        in_meta;
    logic [STAGES-1:0]        stall;
    logic [STAGES-1:0]        flush;
    logic                     clear_cnt;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*XLEN-1:0]   stage_pc;
    logic [STAGES*META_W-1:0] stage_meta;
    logic                     upstream_hold;
    logic [CNT_W-1:0]         kill_cnt;
    modport master (
        output in_valid, in_pc, in_meta, stall, flush, clear_cnt,
        input  stage_valid, stage_pc, stage_meta, upstream_hold, kill_cnt
    );
    modport slave (
        input  in_valid, in_pc, in_meta, stall, flush, clear_cnt,
        output stage_valid, stage_pc, stage_meta, upstream_hold, kill_cnt
    );
endinterface

// File: rtl/pc_pipe_chain.sv
// pc_pipe_chain: STAGES-deep PC/metadata pipeline with per-stage stall/flush, back-pressure and a saturating kill counter.
module pc_pipe_chain #(
    parameter int XLEN             = 32,
    parameter int META_W           = 1,
    parameter int STAGES           = 3,
    parameter int FLUSH_OVER_STALL = 0,
    parameter int CNT_W            = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_pipe_chain_if.slave bus
);
    localparam int PW  = $clog2(STAGES + 1);
    localparam bit FOS = FLUSH_OVER_STALL != 0;
    localparam logic [CNT_W+PW-1:0] CMAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

    logic [STAGES-1:0] v, hold, ph, src_v, clr, kill;
    logic [XLEN-1:0]   pc [STAGES];
    logic [XLEN-1:0]   src_pc [STAGES];
    logic [META_W-1:0] meta [STAGES];
    logic [META_W-1:0] src_meta [STAGES];
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     pop;
    logic [CNT_W+PW-1:0] sum;

    // ph[i] = hold of the stage feeding stage i; a held feeder means stage i takes a bubble
    assign ph = hold << 1;

    for (genvar i = 0; i < STAGES; i++) begin : g_st
        assign hold[i] = |bus.stall[STAGES-1:i];
        if (i == 0) begin : g_in
            assign src_v[i]    = bus.in_valid;
            assign src_pc[i]   = bus.in_pc;
            assign src_meta[i] = bus.in_meta;
        end else begin : g_prev
            assign src_v[i]    = v[i-1];
            assign src_pc[i]   = pc[i-1];
            assign src_meta[i] = meta[i-1];
        end
        assign clr[i]  = bus.flush[i] & (FOS | ~hold[i]);
        assign kill[i] = clr[i] & (hold[i] ? v[i] : src_v[i] & ~ph[i]);
        assign bus.stage_pc[i*XLEN +: XLEN]       = pc[i];
        assign bus.stage_meta[i*META_W +: META_W] = meta[i];
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < STAGES; i++)
            pop = pop + PW'(kill[i]);
    end

    assign sum = (CNT_W+PW)'(cnt) + (CNT_W+PW)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pc[i]   <= '0;
                meta[i] <= '0;
            end
        end else begin
            cnt <= bus.clear_cnt ? '0 : (sum > CMAX ? CMAX[CNT_W-1:0] : sum[CNT_W-1:0]);
            for (int i = 0; i < STAGES; i++) begin
                if (clr[i]) begin
                    v[i]    <= 1'b0;
                    pc[i]   <= '0;
                    meta[i] <= '0;
                end else if (!hold[i]) begin
                    v[i]    <= src_v[i] & ~ph[i];
                    pc[i]   <= ph[i] ? '0 : src_pc[i];
                    meta[i] <= ph[i] ? '0 : src_meta[i];
                end
            end
        end
    end

    assign bus.stage_valid   = v;
    assign bus.upstream_hold = hold[0];
    assign bus.kill_cnt      = cnt;
endmodule

// File: tb/tb_pc_pipe_chain.sv
// tb_pc_pipe_chain: drives stall-priority (CNT_W=16) and flush-priority (CNT_W=2) chains with shared stimulus against a queue-based reference.
module tb_pc_pipe_chain;
    typedef struct packed {
        logic [2:0]  v;
        logic [95:0] pc;
        logic [2:0]  m;
        logic        hold;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    bit          mv  [2][3];
    logic [31:0] mpc [2][3];
    logic        mm  [2][3];
    int          mcnt[2];

    always #5 clk = ~clk;

    pc_pipe_chain_if #(.XLEN(32), .META_W(1), .STAGES(3), .CNT_W(16)) ba();
    pc_pipe_chain_if #(.XLEN(32), .META_W(1), .STAGES(3), .CNT_W(2))  bb();

    pc_pipe_chain #(.XLEN(32), .META_W(1), .STAGES(3), .FLUSH_OVER_STALL(0), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    pc_pipe_chain #(.XLEN(32), .META_W(1), .STAGES(3), .FLUSH_OVER_STALL(1), .CNT_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_a_valid"}, 96'(ba.stage_valid), 0);
        chk({tag, "_a_pc"},    96'(ba.stage_pc), 0);
        chk({tag, "_a_meta"},  96'(ba.stage_meta), 0);
        chk({tag, "_a_cnt"},   96'(ba.kill_cnt), 0);
        chk({tag, "_b_valid"}, 96'(bb.stage_valid), 0);
        chk({tag, "_b_pc"},    96'(bb.stage_pc), 0);
        chk({tag, "_b_meta"},  96'(bb.stage_meta), 0);
        chk({tag, "_b_cnt"},   96'(bb.kill_cnt), 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            for (int i = 0; i < 3; i++) begin
                mv[k][i] = 0; mpc[k][i] = 0; mm[k][i] = 0;
            end
        end
    endtask

    // One clock of the chain: an entry moves on unless something at or after it is stalled.
    task automatic model_step(int k, logic iv, logic [31:0] ipc, logic im,
                              logic [2:0] st, logic [2:0] fl, logic clr);
        bit held[3];
        bit fos;
        int kills, lim;
        fos = (k == 1);
        lim = (k == 0) ? 65535 : 3;
        kills = 0;
        for (int i = 0; i < 3; i++) begin
            held[i] = 0;
            for (int j = i; j < 3; j++) if (st[j]) held[i] = 1;
        end
        for (int i = 2; i >= 0; i--) begin
            bit nv;
            logic [31:0] npc;
            logic nm;
            if (i == 0) begin nv = iv; npc = ipc; nm = im; end
            else begin nv = mv[k][i-1]; npc = mpc[k][i-1]; nm = mm[k][i-1]; end
            if (i > 0 && held[i-1]) begin nv = 0; npc = 0; nm = 0; end
            if (!held[i] || (fos && fl[i])) begin
                if (fl[i]) begin
                    kills += held[i] ? int'(mv[k][i]) : int'(nv);
                    mv[k][i] = 0; mpc[k][i] = 0; mm[k][i] = 0;
                end else begin
                    mv[k][i] = nv; mpc[k][i] = npc; mm[k][i] = nm;
                end
            end
        end
        mcnt[k] = clr ? 0 : ((mcnt[k] + kills > lim) ? lim : mcnt[k] + kills);
    endtask

    function automatic exp_t snap(int k, logic [2:0] st);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.v[i] = mv[k][i];
            e.pc[i*32 +: 32] = mpc[k][i];
            e.m[i] = mm[k][i];
        end
        e.hold = |st;
        e.cnt = 16'(mcnt[k]);
        return e;
    endfunction

    task automatic drive(logic iv, logic [31:0] ipc, logic im,
                         logic [2:0] st, logic [2:0] fl, logic clr);
        @(negedge clk);
        ba.in_valid = iv; ba.in_pc = ipc; ba.in_meta = im;
        ba.stall = st; ba.flush = fl; ba.clear_cnt = clr;
        bb.in_valid = iv; bb.in_pc = ipc; bb.in_meta = im;
        bb.stall = st; bb.flush = fl; bb.clear_cnt = clr;
        model_step(0, iv, ipc, im, st, fl, clr);
        model_step(1, iv, ipc, im, st, fl, clr);
        q_a.push_back(snap(0, st));
        q_b.push_back(snap(1, st));
    endtask

    task automatic compare(string tag, exp_t e, logic [2:0] v, logic [95:0] pc,
                           logic [2:0] m, logic h, logic [15:0] c);
        chk({tag, "_valid"}, 96'(v), 96'(e.v));
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_meta"}, 96'(m), 96'(e.m));
        chk({tag, "_upstream_hold"}, 96'(h), 96'(e.hold));
        chk({tag, "_kill_cnt"}, 96'(c), 96'(e.cnt));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                compare("a", e, ba.stage_valid, ba.stage_pc, ba.stage_meta, ba.upstream_hold, ba.kill_cnt);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                compare("b", e, bb.stage_valid, bb.stage_pc, bb.stage_meta, bb.upstream_hold, {14'b0, bb.kill_cnt});
            end
        end
    end

    initial begin
        ba.in_valid = 0; ba.in_pc = 0; ba.in_meta = 0; ba.stall = 0; ba.flush = 0; ba.clear_cnt = 0;
        bb.in_valid = 0; bb.in_pc = 0; bb.in_meta = 0; bb.stall = 0; bb.flush = 0; bb.clear_cnt = 0;
        model_reset();
        @(posedge clk);
        #3;
        chk_zero("reset");
        rst_n = 1'b1;
        #1;
        chk_zero("release");

        drive(1, 32'h100, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h104, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h108, 0, 3'b000, 3'b000, 0);
        @(posedge clk);
        #2;
        chk("flow_valid", 96'(ba.stage_valid), 96'(3'b111));
        chk("flow_pc2", 96'(ba.stage_pc[95:64]), 96'h100);

        drive(1, 32'h200, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h204, 0, 3'b001, 3'b000, 0);
        drive(1, 32'h204, 0, 3'b001, 3'b000, 0);
        drive(1, 32'h204, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h208, 0, 3'b100, 3'b000, 0);
        drive(1, 32'h208, 0, 3'b100, 3'b000, 0);
        drive(1, 32'h208, 0, 3'b000, 3'b000, 0);

        drive(1, 32'h300, 1, 3'b000, 3'b000, 0);
        drive(1, 32'h304, 0, 3'b001, 3'b001, 0);
        @(posedge clk);
        #2;
        chk("prio_keep_a", 96'({ba.stage_valid[0], ba.stage_meta[0], ba.stage_pc[31:0]}), 96'({2'b11, 32'h300}));
        chk("prio_kill_b", 96'({bb.stage_valid[0], bb.stage_meta[0], bb.stage_pc[31:0]}), 0);
        drive(1, 32'h308, 0, 3'b000, 3'b000, 0);

        drive(1, 32'h400, 0, 3'b000, 3'b000, 1);
        drive(1, 32'h404, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h408, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h40c, 0, 3'b000, 3'b011, 0);
        @(posedge clk);
        #2;
        chk("sat_first", 96'(bb.kill_cnt), 96'd2);
        drive(1, 32'h410, 0, 3'b000, 3'b011, 0);
        drive(1, 32'h414, 0, 3'b000, 3'b011, 0);
        drive(1, 32'h418, 0, 3'b000, 3'b011, 1);
        @(posedge clk);
        #2;
        chk("clear_over_kill", 96'(bb.kill_cnt), 0);

        for (int n = 0; n < 400; n++) begin
            logic [2:0] st, fl;
            st = 3'($urandom) & 3'($urandom);
            fl = 3'($urandom) & 3'($urandom) & 3'($urandom);
            drive(($urandom % 4) != 0, $urandom, 1'($urandom), st, fl, ($urandom % 40) == 0);
        end

        drive(1, 32'h500, 1, 3'b000, 3'b000, 0);
        drive(1, 32'h504, 0, 3'b000, 3'b000, 0);
        drive(1, 32'h508, 1, 3'b000, 3'b001, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("arst_now");
        @(posedge clk);
        #2;
        chk_zero("arst_edge");
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk_zero("arst_release");
        for (int n = 0; n < 20; n++)
            drive(1, 32'h600 + 32'(n * 4), 1'($urandom), 3'($urandom) & 3'($urandom), 3'b000, 0);

        @(posedge clk);
        #3;
        chk("queue_drained", 96'(q_a.size() + q_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_pipe_chain.md
Name: pc_pipe_chain

Overview:
- Parametrised chain of STAGES pipeline registers carrying PC, branch-prediction metadata and a valid bit from ID toward WB.
- Replaces the per-stage single-register PC/predict blocks.
- Adds per-stage stall and flush, a valid bit per stage, back-pressure propagation, selectable stall/flush priority and a saturating kill counter for flushed valid entries.

Parameters:
- XLEN, 32, PC width in bits.
- META_W, 1, prediction metadata width (bit 0 = predict_taken).
- STAGES, 3, number of register stages (index 0 = EX, 1 = MEM, 2 = WB).
- FLUSH_OVER_STALL, 0. 0: stall has priority over flush. 1: flush has priority over stall.
- CNT_W, 16, kill counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  the instruction at the ID output is valid.
- in_pc  input  XLEN  PC from ID.
- in_meta  input  META_W  prediction metadata from ID.
- stall  input  STAGES  per-stage hold request (bubble).
- flush  input  STAGES  per-stage kill request.
- stage_valid  output  STAGES  valid bit of each stage.
- stage_pc  output  STAGES*XLEN  PC per stage, flattened. Stage i occupies bits [i*XLEN +: XLEN].
- stage_meta  output  STAGES*META_W  metadata per stage, flattened in the same way.
- upstream_hold  output  1  hold_0; ID must not advance.
- kill_cnt  output  CNT_W  saturating count of killed valid entries.
- clear_cnt  input  1  synchronous clear of kill_cnt.

Behaviour:
- Reset: rst_n low asynchronously clears all stage_valid, stage_pc and stage_meta to 0, and kill_cnt to 0. This holds even mid-operation. The first capture happens at the first clk edge after rst_n goes high.
- Source of stage i (src_i): in_* for i = 0; stage i-1 registers for i > 0.
- Hold chain, combinational:
  - hold_{STAGES-1} = stall[STAGES-1].
  - hold_i = stall[i] | hold_{i+1}.
  - upstream_hold = hold_0.
- Per stage, at each clk edge, with FLUSH_OVER_STALL = 0:
  - hold_i = 1: stage keeps its value; flush[i] is ignored.
  - hold_i = 0 and flush[i] = 1: valid, pc and meta are set to 0.
  - hold_i = 0 and flush[i] = 0: stage loads src_i.
  - Bubble insertion: if hold_{i-1} = 1 and hold_i = 0, stage i loads valid = 0, pc = 0, meta = 0, so the held entry is not duplicated.
- With FLUSH_OVER_STALL = 1:
  - flush[i] = 1 clears stage i to 0 whether or not it is held.
  - The hold chain itself is unchanged by flush.
- Latency:
  - A non-held entry advances one stage per cycle.
  - in_* appears on stage 0 one cycle after capture and on stage STAGES-1 after STAGES cycles.
- Kill accounting:
  - kill_i = 1 when the flush rule clears stage i and the value that would otherwise have been written is valid.
  - That value is src_i valid when loading, or the stage's own valid when held with FLUSH_OVER_STALL = 1.
  - Each cycle kill_cnt += popcount(kill), saturating at 2^CNT_W - 1 with no wrap.
  - clear_cnt has priority: kill_cnt becomes 0 and that cycle's kills are dropped.
- Simultaneous stall[i] and flush[j] with j > i: stage j receives a bubble (valid 0) and is flushed. No kill is counted, because the bubble is not valid.
- Stall without flush never loses or duplicates a valid entry.
- stage_pc and stage_meta are registered outputs with no combinational path from inputs.
- upstream_hold is combinational from stall.

Test Plan:
- Reset/flow: release rst_n, drive in_valid = 1 and in_pc = 0x100, 0x104, 0x108 on consecutive cycles with no stall or flush. Required:
  - stage_pc[0] = 0x100 at cycle 1.
  - stage_pc[2] = 0x100 at cycle 3.
  - stage_valid = 3'b111 at cycle 3.
  - kill_cnt = 0.
- Stall bubble: with 0x200 in stage 0, assert stall[0] for 2 cycles. Required:
  - Stage 0 holds 0x200.
  - Stage 1 shows valid = 0, pc = 0 for 2 cycles, then 0x200.
  - upstream_hold = 1 during the stall.
- Back-pressure: assert stall[2] only. Required:
  - upstream_hold = 1.
  - All stages hold their values.
  - No bubbles appear.
- Flush priority: stall[0] = 1 and flush[0] = 1 with 0x300 held in stage 0, predict_taken = 1. Required:
  - FLUSH_OVER_STALL = 0: 0x300 is kept and kill_cnt is unchanged.
  - FLUSH_OVER_STALL = 1: stage 0 becomes valid = 0, pc = 0, meta = 0, and kill_cnt increments by 1.
- Multi-kill/saturation: with CNT_W = 2 and all stages valid, assert flush = 3'b011 for 2 cycles. Required:
  - kill_cnt = 2 after cycle 1 and saturates at 3 afterwards.
  - Asserting clear_cnt together with a flush gives kill_cnt = 0.
- Async reset mid-stream: drop rst_n between clock edges while the stages are full. Required:
  - All outputs read 0 immediately, without waiting for a clk edge.
  - They stay 0 until the first clk edge after release.
